// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its sequencing controller.
package instr_register_pkg;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [AW-1:0]      address_t;
    typedef logic [AW:0]        count_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } ctrl_state_t;

    // Division-type opcodes with a zero divisor are never stored
    function automatic logic is_div0(opcode_t op, operand_t b);
        return ((op == DIV) || (op == MOD)) && (b == '0);
    endfunction

endpackage

// File: rtl/instr_reg_ctrl_if.sv
// Producer/consumer handshakes plus the register-side control bus of instr_reg_ctrl.
interface instr_reg_ctrl_if;
    import instr_register_pkg::*;

    logic         in_valid;
    logic         in_ready;
    opcode_t      in_opcode;
    operand_t     in_operand_a;
    operand_t     in_operand_b;
    logic         rd_req;
    logic         rd_ack;
    logic         rd_valid;
    instruction_t rd_data;
    logic         flush;
    logic         full;
    logic         empty;
    count_t       count;
    logic         err_div0;
    logic         reset_n;
    logic         load_en;
    address_t     write_pointer;
    address_t     read_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    result_t      result;
    instruction_t instruction_word;

    modport master (
        output in_valid, in_opcode, in_operand_a, in_operand_b, rd_req, flush,
               instruction_word,
        input  in_ready, rd_ack, rd_valid, rd_data, full, empty, count, err_div0,
               reset_n, load_en, write_pointer, read_pointer, opcode, operand_a,
               operand_b, result
    );

    modport slave (
        input  in_valid, in_opcode, in_operand_a, in_operand_b, rd_req, flush,
               instruction_word,
        output in_ready, rd_ack, rd_valid, rd_data, full, empty, count, err_div0,
               reset_n, load_en, write_pointer, read_pointer, opcode, operand_a,
               operand_b, result
    );

endinterface

// File: rtl/instr_reg_ctrl.sv
// Circular-queue sequencer for the 32-entry instruction register: round-robin
// arbitration between producer writes and consumer readbacks, one op at a time.
module instr_reg_ctrl
    import instr_register_pkg::*;
(
    input logic             clk,
    input logic             reset,
    instr_reg_ctrl_if.slave bus
);

    ctrl_state_t  state_q, state_d;
    logic         last_grant_q, last_grant_d;   // 1: read won the last tie
    address_t     wr_ptr_q, rd_ptr_q;
    count_t       count_q;
    opcode_t      opc_q;
    operand_t     a_q, b_q;
    logic         rd_valid_q, err_div0_q;
    instruction_t rd_data_q;

    logic full_c, empty_c, active, wr_cand, rd_cand;
    logic grant_wr, grant_rd, div0_hit, do_write, do_read;

    // Arbitration and next-state
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        div0_hit     = 1'b0;
        do_write     = 1'b0;
        do_read      = 1'b0;
        full_c       = (count_q == count_t'(DEPTH));
        empty_c      = (count_q == '0);
        active       = !reset && !bus.flush;
        wr_cand      = bus.in_valid && !full_c;
        rd_cand      = bus.rd_req && !empty_c;

        unique case (state_q)
            IDLE: begin
                if (active) begin
                    if (wr_cand && rd_cand) begin
                        grant_wr     = last_grant_q;
                        grant_rd     = !last_grant_q;
                        last_grant_d = !last_grant_q;
                    end else begin
                        grant_wr = wr_cand;
                        grant_rd = rd_cand;
                    end
                    if (grant_wr) begin
                        div0_hit = is_div0(bus.in_opcode, bus.in_operand_b);
                        state_d  = div0_hit ? IDLE : WRITE;
                    end else if (grant_rd) begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                do_write = active;
                state_d  = IDLE;
            end
            READ: begin
                do_read = active;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!active) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Pointers, occupancy, latched instruction and readback capture
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            opc_q        <= ZERO;
            a_q          <= '0;
            b_q          <= '0;
            rd_valid_q   <= 1'b0;
            err_div0_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_valid_q   <= 1'b0;
            err_div0_q   <= div0_hit;
            if (grant_wr) begin
                opc_q <= bus.in_opcode;
                a_q   <= bus.in_operand_a;
                b_q   <= bus.in_operand_b;
            end
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_write) begin
                    wr_ptr_q <= wr_ptr_q + address_t'(1);
                    count_q  <= count_q + count_t'(1);
                end
                if (do_read) begin
                    rd_data_q  <= bus.instruction_word;
                    rd_valid_q <= 1'b1;
                    rd_ptr_q   <= rd_ptr_q + address_t'(1);
                    count_q    <= count_q - count_t'(1);
                end
            end
        end
    end

    assign bus.in_ready      = grant_wr;
    assign bus.rd_ack        = grant_rd;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.err_div0      = err_div0_q;
    assign bus.full          = full_c && !reset;
    assign bus.empty         = empty_c || reset;
    assign bus.count         = count_q;
    assign bus.reset_n       = ~reset;
    assign bus.load_en       = do_write;
    assign bus.write_pointer = wr_ptr_q;
    assign bus.read_pointer  = rd_ptr_q;
    assign bus.opcode        = opc_q;
    assign bus.operand_a     = a_q;
    assign bus.operand_b     = b_q;
    assign bus.result        = '0;

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl with a behavioural stand-in for the instruction register.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_reg_ctrl_if bus();

    instr_reg_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register model: stores the instruction and computes its result on write
    instruction_t mem [DEPTH];

    function automatic result_t calc(opcode_t op, operand_t a, operand_t b);
        case (op)
            PASSA:   return result_t'(a);
            PASSB:   return result_t'(b);
            ADD:     return result_t'(a) + result_t'(b);
            SUB:     return result_t'(a) - result_t'(b);
            MULT:    return result_t'(a) * result_t'(b);
            DIV:     return (b == 0) ? '0 : result_t'(a / b);
            MOD:     return (b == 0) ? '0 : result_t'(a % b);
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!bus.reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.load_en) begin
            mem[bus.write_pointer] <= '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b,
                                        res: calc(bus.opcode, bus.operand_a, bus.operand_b)};
        end
    end

    assign bus.instruction_word = mem[bus.read_pointer];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic write_op(input opcode_t op, input int a, input int b, input int exp_wp);
        int n;
        n = 0;
        bus.in_opcode    = op;
        bus.in_operand_a = operand_t'(a);
        bus.in_operand_b = operand_t'(b);
        bus.in_valid     = 1'b1;
        settle();
        while (!bus.in_ready && n < 8) begin
            tick();
            settle();
            n++;
        end
        chk("wr_handshake", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("wr_load_en", 64'(bus.load_en), 64'(1));
        chk("wr_pointer", 64'(bus.write_pointer), 64'(exp_wp));
        tick();
    endtask

    task automatic read_op(input result_t exp_res);
        int n;
        n = 0;
        bus.rd_req = 1'b1;
        settle();
        while (!bus.rd_ack && n < 8) begin
            tick();
            settle();
            n++;
        end
        chk("rd_ack", 64'(bus.rd_ack), 64'(1));
        tick();
        bus.rd_req = 1'b0;
        settle();
        chk("rd_valid_early", 64'(bus.rd_valid), 64'(0));
        tick();
        settle();
        chk("rd_valid", 64'(bus.rd_valid), 64'(1));
        chk("rd_result", 64'(bus.rd_data.res), 64'(exp_res));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid     = 1'b1;
        bus.rd_req       = 1'b1;
        bus.flush        = 1'b0;
        bus.in_opcode    = ADD;
        bus.in_operand_a = '0;
        bus.in_operand_b = '0;
        reset            = 1'b1;

        // Reset values, with requests held high to prove gating
        tick();
        tick();
        settle();
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_rd_ack", 64'(bus.rd_ack), 64'(0));
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("rst_rd_data", 64'(bus.rd_data.res), 64'(0));
        chk("rst_err_div0", 64'(bus.err_div0), 64'(0));
        chk("rst_load_en", 64'(bus.load_en), 64'(0));
        chk("rst_full", 64'(bus.full), 64'(0));
        chk("rst_empty", 64'(bus.empty), 64'(1));
        chk("rst_count", 64'(bus.count), 64'(0));
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        reset        = 1'b0;
        tick();

        // Three writes then three in-order reads
        write_op(ADD, 5, 3, 0);
        chk("t1_count1", 64'(bus.count), 64'(1));
        write_op(SUB, 9, 4, 1);
        chk("t1_count2", 64'(bus.count), 64'(2));
        write_op(MULT, 6, 7, 2);
        chk("t1_count3", 64'(bus.count), 64'(3));
        read_op(64'sd8);
        chk("t1_count4", 64'(bus.count), 64'(2));
        read_op(64'sd5);
        chk("t1_count5", 64'(bus.count), 64'(1));
        read_op(64'sd42);
        chk("t1_count6", 64'(bus.count), 64'(0));
        chk("t1_empty", 64'(bus.empty), 64'(1));

        // Fill to full, stall, drain one, wrap the write pointer
        do_reset();
        for (int i = 0; i < 32; i++) write_op(ADD, i, 100, i);
        chk("t2_full", 64'(bus.full), 64'(1));
        chk("t2_count", 64'(bus.count), 64'(32));
        bus.in_opcode    = ADD;
        bus.in_operand_a = operand_t'(999);
        bus.in_operand_b = '0;
        bus.in_valid     = 1'b1;
        settle();
        chk("t2_stall0", 64'(bus.in_ready), 64'(0));
        tick();
        settle();
        chk("t2_stall1", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b0;
        tick();
        read_op(64'sd100);
        chk("t2_not_full", 64'(bus.full), 64'(0));
        chk("t2_count31", 64'(bus.count), 64'(31));
        write_op(ADD, 1000, 0, 0);
        chk("t2_full_again", 64'(bus.full), 64'(1));
        for (int i = 1; i < 32; i++) read_op(result_t'(100 + i));
        read_op(64'sd1000);
        chk("t2_empty", 64'(bus.empty), 64'(1));

        // Simultaneous requests alternate, starting with write after reset
        do_reset();
        for (int i = 0; i < 4; i++) write_op(ADD, 1, 1, i);
        chk("t3_count4", 64'(bus.count), 64'(4));
        bus.in_opcode    = ADD;
        bus.in_operand_a = operand_t'(2);
        bus.in_operand_b = operand_t'(2);
        bus.in_valid     = 1'b1;
        bus.rd_req       = 1'b1;
        for (int g = 0; g < 10; g++) begin
            int n;
            n = 0;
            settle();
            while (!(bus.in_ready || bus.rd_ack) && n < 6) begin
                tick();
                settle();
                n++;
            end
            chk("t3_grant", 64'({bus.in_ready, bus.rd_ack}),
                (g % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            tick();
        end
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        tick();
        tick();
        chk("t3_count_end", 64'(bus.count), 64'(4));

        // Divide by zero is accepted and dropped; valid divide is stored
        do_reset();
        bus.in_opcode    = DIV;
        bus.in_operand_a = operand_t'(10);
        bus.in_operand_b = '0;
        bus.in_valid     = 1'b1;
        settle();
        chk("t4_div0_ready", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("t4_err_pulse", 64'(bus.err_div0), 64'(1));
        chk("t4_no_load", 64'(bus.load_en), 64'(0));
        chk("t4_count", 64'(bus.count), 64'(0));
        tick();
        settle();
        chk("t4_err_clear", 64'(bus.err_div0), 64'(0));
        chk("t4_no_load2", 64'(bus.load_en), 64'(0));
        chk("t4_count2", 64'(bus.count), 64'(0));
        write_op(DIV, 10, 2, 0);
        chk("t4_count_div", 64'(bus.count), 64'(1));
        read_op(64'sd5);

        // Flush during WRITE with three entries queued
        write_op(ADD, 1, 2, 1);
        write_op(ADD, 3, 4, 2);
        write_op(ADD, 5, 6, 3);
        chk("t5_count3", 64'(bus.count), 64'(3));
        bus.in_opcode    = ADD;
        bus.in_operand_a = operand_t'(7);
        bus.in_operand_b = operand_t'(8);
        bus.in_valid     = 1'b1;
        settle();
        chk("t5_ready", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        settle();
        chk("t5_flush_load_en", 64'(bus.load_en), 64'(0));
        tick();
        bus.flush = 1'b0;
        settle();
        chk("t5_count0", 64'(bus.count), 64'(0));
        chk("t5_empty", 64'(bus.empty), 64'(1));
        chk("t5_wp0", 64'(bus.write_pointer), 64'(0));
        chk("t5_rp0", 64'(bus.read_pointer), 64'(0));
        chk("t5_no_write", 64'(mem[4].res), 64'(0));
        bus.rd_req = 1'b1;
        settle();
        chk("t5_no_ack0", 64'(bus.rd_ack), 64'(0));
        tick();
        settle();
        chk("t5_no_ack1", 64'(bus.rd_ack), 64'(0));
        chk("t5_no_valid", 64'(bus.rd_valid), 64'(0));
        bus.rd_req = 1'b0;
        tick();

        // Reset during READ
        write_op(ADD, 20, 22, 0);
        chk("t6_count1", 64'(bus.count), 64'(1));
        bus.rd_req = 1'b1;
        settle();
        chk("t6_ack", 64'(bus.rd_ack), 64'(1));
        tick();
        bus.rd_req = 1'b0;
        reset      = 1'b1;
        settle();
        chk("t6_load_en", 64'(bus.load_en), 64'(0));
        tick();
        reset = 1'b0;
        settle();
        chk("t6_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("t6_rd_data", 64'(bus.rd_data.res), 64'(0));
        chk("t6_count", 64'(bus.count), 64'(0));
        chk("t6_empty", 64'(bus.empty), 64'(1));
        chk("t6_full", 64'(bus.full), 64'(0));
        chk("t6_err", 64'(bus.err_div0), 64'(0));
        chk("t6_wp", 64'(bus.write_pointer), 64'(0));
        chk("t6_rp", 64'(bus.read_pointer), 64'(0));
        chk("t6_in_ready", 64'(bus.in_ready), 64'(0));
        chk("t6_rd_ack", 64'(bus.rd_ack), 64'(0));
        tick();
        settle();
        chk("t6_rd_valid_late", 64'(bus.rd_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
